inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit_pkg.sv | 27 ++
 rtl/inst_fetch_unit_decode.sv | 33 +++
 rtl/inst_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and later pipeline stages.
//   - state_e        : fetch FSM states
//   - *_HI / *_LO    : instruction field bit positions inside IR
//   - PC_INC         : byte increment between sequential fetches
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam int MODE_HI = 31;
    localparam int MODE_LO = 27;
    localparam int W_HI    = 26;
    localparam int W_LO    = 23;
    localparam int A_HI    = 22;
    localparam int A_LO    = 19;
    localparam int B_HI    = 18;
    localparam int B_LO    = 15;
    localparam int C_HI    = 14;
    localparam int C_LO    = 11;

    localparam int PC_INC  = 4;

endpackage

// File: rtl/inst_fetch_unit_decode.sv
// inst_field_decode: purely combinational split of an instruction word into
// its mode and register-address fields. Stateless so any stage can reuse it.
//   ir       in   SIZE  instruction word
//   m        out  5     work mode
//   w_addr   out  ADDR  write-register address
//   r_addr_a out  ADDR  read address A
//   r_addr_b out  ADDR  read address B
//   r_addr_c out  ADDR  read address C
module inst_field_decode
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR = 4,
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] ir,
    output logic [4:0]      m,
    output logic [ADDR-1:0] w_addr,
    output logic [ADDR-1:0] r_addr_a,
    output logic [ADDR-1:0] r_addr_b,
    output logic [ADDR-1:0] r_addr_c
);

    assign m        = ir[MODE_HI:MODE_LO];
    assign w_addr   = ir[W_LO +: ADDR];
    assign r_addr_a = ir[A_LO +: ADDR];
    assign r_addr_b = ir[B_LO +: ADDR];
    assign r_addr_c = ir[C_LO +: ADDR];

    // Low bits below the last field carry immediates for later stages.
    logic unused_low;
    assign unused_low = ^ir[C_LO-1:0];

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetches one instruction word at a time from instruction
// memory, holds it for the execute stage and follows PC redirects.
//   Clk, Rst                      clock, synchronous active-low reset
//   Write_PC, PC_New              redirect request and target
//   Mem_Req, Mem_Addr             memory request, held until Mem_Ack
//   Mem_Ack, Mem_Data             memory response
//   Inst_Valid, Inst_Ready        instruction handshake
//   IR, Inst_PC                   held instruction and its address
//   M, W_Addr, R_Addr_A/B/C       decoded fields of IR
//   Write_Reg                     register-write enable
//   Fetch_Cnt                     number of delivered instructions
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int              ADDR     = 4,
    parameter int              SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Write_PC,
    input  logic [SIZE-1:0] PC_New,
    output logic            Mem_Req,
    output logic [SIZE-1:0] Mem_Addr,
    input  logic            Mem_Ack,
    input  logic [SIZE-1:0] Mem_Data,
    output logic            Inst_Valid,
    input  logic            Inst_Ready,
    output logic [SIZE-1:0] IR,
    output logic [SIZE-1:0] Inst_PC,
    output logic [4:0]      M,
    output logic [ADDR-1:0] W_Addr,
    output logic [ADDR-1:0] R_Addr_A,
    output logic [ADDR-1:0] R_Addr_B,
    output logic [ADDR-1:0] R_Addr_C,
    output logic            Write_Reg,
    output logic [15:0]     Fetch_Cnt
);

    state_e          state_q, state_d;
    logic [SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [SIZE-1:0] pend_pc_q, pend_pc_d;
    logic [SIZE-1:0] ir_q, ir_d;
    logic [SIZE-1:0] inst_pc_q, inst_pc_d;
    logic [15:0]     fetch_cnt_q, fetch_cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            inst_valid_q, inst_valid_d;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pend_pc_d   = pend_pc_q;
        ir_d        = ir_q;
        inst_pc_d   = inst_pc_q;
        fetch_cnt_d = fetch_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Write_PC) fetch_pc_d = PC_New;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (Mem_Ack) begin
                    if (Write_PC) begin
                        // Returned word belongs to the abandoned path.
                        fetch_pc_d = PC_New;
                    end else begin
                        ir_d       = Mem_Data;
                        inst_pc_d  = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + SIZE'(PC_INC);
                        state_d    = ST_VALID;
                    end
                end else if (Write_PC) begin
                    // Request must stay stable until acked, so park the
                    // target and drain the outstanding access first.
                    pend_pc_d = PC_New;
                    state_d   = ST_FLUSH;
                end
            end
            ST_VALID: begin
                if (Inst_Ready) begin
                    fetch_cnt_d = fetch_cnt_q + 16'd1;
                    state_d     = ST_FETCH;
                end
                if (Write_PC) begin
                    fetch_pc_d = PC_New;
                    state_d    = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (Write_PC) pend_pc_d = PC_New;
                if (Mem_Ack) begin
                    // Last redirect wins, even one arriving with the ack.
                    fetch_pc_d = Write_PC ? PC_New : pend_pc_q;
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mem_req_d    = (state_d == ST_FETCH) || (state_d == ST_FLUSH);
        inst_valid_d = (state_d == ST_VALID);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= '0;
            ir_q         <= '0;
            inst_pc_q    <= '0;
            fetch_cnt_q  <= '0;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pend_pc_q    <= pend_pc_d;
            ir_q         <= ir_d;
            inst_pc_q    <= inst_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign Mem_Req    = mem_req_q;
    assign Mem_Addr   = fetch_pc_q;
    assign Inst_Valid = inst_valid_q;
    assign IR         = ir_q;
    assign Inst_PC    = inst_pc_q;
    assign Fetch_Cnt  = fetch_cnt_q;
    assign Write_Reg  = inst_valid_q & M[4];

    inst_field_decode #(
        .ADDR (ADDR),
        .SIZE (SIZE)
    ) u_decode (
        .ir       (ir_q),
        .m        (M),
        .w_addr   (W_Addr),
        .r_addr_a (R_Addr_A),
        .r_addr_b (R_Addr_B),
        .r_addr_c (R_Addr_C)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit. A memory responder answers requests with
// configurable latency; a reference model predicts the next delivered
// instruction as "last redirect target, else previous PC + 4" and the
// delivered count, and a negedge monitor compares against it.
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Write_PC = 1'b0;
    logic [31:0] PC_New = '0;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack = 1'b0;
    logic [31:0] Mem_Data = '0;
    logic        Inst_Valid;
    logic        Inst_Ready = 1'b0;
    logic [31:0] IR, Inst_PC;
    logic [4:0]  M;
    logic [3:0]  W_Addr, R_Addr_A, R_Addr_B, R_Addr_C;
    logic        Write_Reg;
    logic [15:0] Fetch_Cnt;

    inst_fetch_unit #(.ADDR(4), .SIZE(32), .RESET_PC(RST_PC)) dut (
        .Clk(Clk), .Rst(Rst), .Write_PC(Write_PC), .PC_New(PC_New),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack),
        .Mem_Data(Mem_Data), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
        .IR(IR), .Inst_PC(Inst_PC), .M(M), .W_Addr(W_Addr),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Addr_C(R_Addr_C),
        .Write_Reg(Write_Reg), .Fetch_Cnt(Fetch_Cnt)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory image: low region is a fixed instruction, elsewhere a hash.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a < 32'h40) return 32'h8440_0000;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- memory responder ----------------
    int fixed_wait = 0;   // >=0: fixed latency, <0: random up to max_wait
    int max_wait   = 0;
    int w_left     = 0;
    bit fresh      = 1'b1;
    bit done_prev;

    always @(posedge Clk) begin
        done_prev = Mem_Req && Mem_Ack;
        if (done_prev) fresh = 1'b1;
        #1;
        if (!Mem_Req) begin
            fresh   = 1'b1;
            Mem_Ack = 1'b0;
        end else begin
            if (fresh) begin
                w_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(max_wait, 0);
                fresh  = 1'b0;
            end
            if (w_left == 0) begin
                Mem_Ack  = 1'b1;
                Mem_Data = mem_fn(Mem_Addr);
            end else begin
                Mem_Ack  = 1'b0;
                Mem_Data = $urandom;
                w_left--;
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] exp_cnt = '0;
    bit          started = 1'b0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    int          hs_total = 0;
    bit          preload_pulse = 1'b0;
    logic [15:0] preload_val = '0;

    always @(negedge Clk) begin
        exp_t nx;
        if (preload_pulse) exp_cnt = preload_val;
        if (started) begin
            chk("fetch_cnt", {16'h0, Fetch_Cnt}, {16'h0, exp_cnt});
            if (Mem_Req && Inst_Valid) chk("req_and_valid", 32'd1, 32'd0);
            if (Inst_Valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    chk("inst_pc", Inst_PC, sb_q[0].pc);
                    chk("ir", IR, sb_q[0].data);
                    chk("m", {27'h0, M}, {27'h0, sb_q[0].data[31:27]});
                    chk("w_addr", {28'h0, W_Addr}, {28'h0, sb_q[0].data[26:23]});
                    chk("r_addr_a", {28'h0, R_Addr_A}, {28'h0, sb_q[0].data[22:19]});
                    chk("r_addr_b", {28'h0, R_Addr_B}, {28'h0, sb_q[0].data[18:15]});
                    chk("r_addr_c", {28'h0, R_Addr_C}, {28'h0, sb_q[0].data[14:11]});
                    chk("write_reg", {31'h0, Write_Reg}, {31'h0, sb_q[0].data[31]});
                end
            end else begin
                chk("write_reg_idle", {31'h0, Write_Reg}, 32'd0);
            end
            if (prev_pend && Mem_Req) chk("mem_addr_hold", Mem_Addr, prev_addr);
        end
        prev_pend = Rst && Mem_Req && !Mem_Ack;
        prev_addr = Mem_Addr;
        if (!Rst) begin
            started = 1'b1;
            sb_q.delete();
            sb_q.push_back('{RST_PC, mem_fn(RST_PC)});
            exp_cnt = '0;
        end else if (started) begin
            if (Inst_Valid && Inst_Ready && sb_q.size() != 0) begin
                nx.pc   = sb_q[0].pc + 32'd4;
                nx.data = mem_fn(nx.pc);
                void'(sb_q.pop_front());
                sb_q.push_back(nx);
                exp_cnt = exp_cnt + 16'd1;
                hs_total++;
            end
            if (Write_PC) begin
                sb_q.delete();
                sb_q.push_back('{PC_New, mem_fn(PC_New)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!Inst_Valid && n < 20) begin
            tick();
            n++;
        end
        chk(nm, {31'h0, Inst_Valid}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_mem_req", {31'h0, Mem_Req}, 32'd0);
        chk("rst_mem_addr", Mem_Addr, RST_PC);
        chk("rst_valid", {31'h0, Inst_Valid}, 32'd0);
        chk("rst_ir", IR, 32'd0);
        chk("rst_inst_pc", Inst_PC, 32'd0);
        chk("rst_fields", {M, W_Addr, R_Addr_A, R_Addr_B, R_Addr_C}, 32'd0);
        chk("rst_write_reg", {31'h0, Write_Reg}, 32'd0);
        chk("rst_cnt", {16'h0, Fetch_Cnt}, 32'd0);

        // Zero-wait streaming, one instruction per two cycles
        Rst = 1'b1; Inst_Ready = 1'b1; fixed_wait = 0;
        chk("idle_no_req", {31'h0, Mem_Req}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("stream_req", {31'h0, Mem_Req}, 32'd1);
            chk("stream_addr", Mem_Addr, 32'(4 * k));
            chk("stream_cnt", {16'h0, Fetch_Cnt}, 32'(k));
            tick();
            chk("stream_valid", {31'h0, Inst_Valid}, 32'd1);
            chk("stream_m", {27'h0, M}, 32'h10);
            chk("stream_w", {28'h0, W_Addr}, 32'd8);
            chk("stream_a", {28'h0, R_Addr_A}, 32'd8);
            chk("stream_wr", {31'h0, Write_Reg}, 32'd1);
            tick();
        end
        repeat (8) tick();
        chk("cnt_rate", {16'h0, Fetch_Cnt}, 32'd8);

        // Back-pressure holds the instruction
        Inst_Ready = 1'b0;
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {31'h0, Inst_Valid}, 32'd1);
            chk("bp_hold_ir", IR, 32'h8440_0000);
            chk("bp_hold_pc", Inst_PC, 32'h20);
            chk("bp_no_req", {31'h0, Mem_Req}, 32'd0);
            chk("bp_cnt", {16'h0, Fetch_Cnt}, 32'd8);
            tick();
        end

        // Redirect during a slow fetch goes through FLUSH
        fixed_wait = 3; Inst_Ready = 1'b1;
        tick();
        chk("fl_req", {31'h0, Mem_Req}, 32'd1);
        chk("fl_addr", Mem_Addr, 32'h24);
        Inst_Ready = 1'b0; Write_PC = 1'b1; PC_New = 32'h40;
        tick();
        Write_PC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fl_hold_req", {31'h0, Mem_Req}, 32'd1);
            chk("fl_hold_addr", Mem_Addr, 32'h24);
            chk("fl_no_valid", {31'h0, Inst_Valid}, 32'd0);
            tick();
        end
        chk("fl_new_addr", Mem_Addr, 32'h40);
        chk("fl_new_valid", {31'h0, Inst_Valid}, 32'd0);

        // Redirect and handshake in the same VALID cycle
        fixed_wait = 0;
        wait_valid("rd_valid");
        chk("rd_pc", Inst_PC, 32'h40);
        Inst_Ready = 1'b1; Write_PC = 1'b1; PC_New = 32'h100;
        tick();
        Write_PC = 1'b0; Inst_Ready = 1'b0;
        chk("rd_cnt", {16'h0, Fetch_Cnt}, 32'd10);
        chk("rd_addr", Mem_Addr, 32'h100);
        chk("rd_req", {31'h0, Mem_Req}, 32'd1);

        // PC wrap and counter wrap
        wait_valid("wr_valid0");
        Write_PC = 1'b1; PC_New = 32'hFFFF_FFFC;
        tick();
        Write_PC = 1'b0;
        wait_valid("wr_valid1");
        chk("wr_pc", Inst_PC, 32'hFFFF_FFFC);
        chk("wr_next_addr", Mem_Addr, 32'h0);
        preload_val = 16'hFFFF; preload_pulse = 1'b1;
        force dut.fetch_cnt_q = 16'hFFFF;
        #1;
        release dut.fetch_cnt_q;
        tick();
        preload_pulse = 1'b0;
        chk("wr_cnt_max", {16'h0, Fetch_Cnt}, 32'hFFFF);
        Inst_Ready = 1'b1;
        tick();
        Inst_Ready = 1'b0;
        chk("wr_cnt_zero", {16'h0, Fetch_Cnt}, 32'd0);
        chk("wr_req_addr", Mem_Addr, 32'h0);

        // Reset while flushing
        wait_valid("rf_valid");
        fixed_wait = 3; Inst_Ready = 1'b1;
        tick();
        Inst_Ready = 1'b0; Write_PC = 1'b1; PC_New = 32'h80;
        tick();
        Write_PC = 1'b0;
        chk("rf_flush_req", {31'h0, Mem_Req}, 32'd1);
        chk("rf_flush_addr", Mem_Addr, 32'h4);
        Rst = 1'b0;
        tick();
        chk("rf_req", {31'h0, Mem_Req}, 32'd0);
        chk("rf_valid0", {31'h0, Inst_Valid}, 32'd0);
        chk("rf_addr", Mem_Addr, RST_PC);
        chk("rf_cnt", {16'h0, Fetch_Cnt}, 32'd0);
        tick();
        Rst = 1'b1;
        chk("rf_idle_req", {31'h0, Mem_Req}, 32'd0);
        tick();
        chk("rf_first_req", {31'h0, Mem_Req}, 32'd1);
        chk("rf_first_addr", Mem_Addr, RST_PC);

        // Randomised traffic against the model
        fixed_wait = -1; max_wait = 2;
        for (int c = 0; c < 1500; c++) begin
            Inst_Ready = ($urandom_range(9, 0) < 7);
            Write_PC   = ($urandom_range(11, 0) == 0);
            PC_New     = $urandom;
            if ($urandom_range(1, 0) == 0) PC_New[1:0] = 2'b00;
            Rst        = ($urandom_range(149, 0) != 0);
            tick();
        end
        Rst = 1'b1; Write_PC = 1'b0; Inst_Ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (hs_total < 50) begin
            errors++;
            $display("FAIL handshakes: got %0d expected >= 50", hs_total);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
